time_set_ctrl: RTL and testbench

Time-of-day core for the clock design. Consumes the one-cycle debounced key pulses (mode, up, down) and a 1 Hz tick. Maintains HH:MM:SS in packed BCD (24 h). A mode state machine lets the user stop the clock and edit hours, minutes and seconds, with a blink flag for the display driver.

---
 rtl/clock_pkg.sv | 43 ++++
 rtl/bcd_field_counter.sv | 52 +++++
 rtl/time_set_ctrl.sv | 137 +++++++++++++
 tb/tb_time_set_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types, mode encoding, field limits and BCD step helpers for the clock core.
package clock_pkg;

  typedef logic [7:0] bcd_t;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_SEC  = 2'd3
  } mode_t;

  localparam bcd_t SEC_MAX  = 8'h59;
  localparam bcd_t MIN_MAX  = 8'h59;
  localparam bcd_t HOUR_MAX = 8'h23;

  // Next BCD value going up; the field maximum wraps to 00.
  function automatic bcd_t bcd_inc(input bcd_t v, input bcd_t max);
    bcd_t r;
    if (v == max) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Next BCD value going down; 00 wraps to the field maximum.
  function automatic bcd_t bcd_dec(input bcd_t v, input bcd_t max);
    bcd_t r;
    if (v == 8'h00) begin
      r = max;
    end else if (v[3:0] == 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_field_counter.sv
// One BCD time field (hour, minute or second) with wrap-around up/down stepping.
// carry is a registered pulse marking an upward wrap from MAX to 00.
module bcd_field_counter
  import clock_pkg::*;
#(
  parameter bcd_t MAX  = 8'h59,
  parameter bcd_t INIT = 8'h00
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output bcd_t value,
  output logic carry
);

  bcd_t value_r;
  bcd_t value_s;
  logic carry_r;
  logic carry_s;

  // Next field value; simultaneous inc and dec cancel out.
  always_comb begin
    value_s = value_r;
    carry_s = 1'b0;
    if (inc && !dec) begin
      value_s = bcd_inc(value_r, MAX);
      carry_s = (value_r == MAX);
    end else if (dec && !inc) begin
      value_s = bcd_dec(value_r, MAX);
      carry_s = 1'b0;
    end else begin
      value_s = value_r;
      carry_s = 1'b0;
    end
  end

  // Field register and wrap pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value_r <= INIT;
      carry_r <= 1'b0;
    end else begin
      value_r <= value_s;
      carry_r <= carry_s;
    end
  end

  assign value = value_r;
  assign carry = carry_r;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-of-day core: runs HH:MM:SS in BCD from a 1 Hz tick and lets the user
// stop the clock and edit each field, with a blink flag for the display.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter bcd_t INIT_HOUR = 8'h00,
  parameter bcd_t INIT_MIN  = 8'h00,
  parameter bcd_t INIT_SEC  = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       blink_tick,
  input  logic       key_mode,
  input  logic       key_up,
  input  logic       key_down,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] mode,
  output logic       blink_on,
  output logic       midnight
);

  mode_t mode_r;
  mode_t mode_s;
  logic  blink_r;
  logic  blink_s;
  bcd_t  hour_val_s;
  bcd_t  min_val_s;
  bcd_t  sec_val_s;
  logic  hour_carry_s;
  logic  min_carry_s;
  logic  sec_carry_s;
  logic  run_s;
  logic  tick_s;
  logic  edit_s;
  logic  up_s;
  logic  down_s;
  logic  sec_inc_s;
  logic  sec_dec_s;
  logic  min_inc_s;
  logic  min_dec_s;
  logic  hour_inc_s;
  logic  hour_dec_s;

  // Field step requests: chained carries while running, single-field edits otherwise.
  always_comb begin
    run_s      = (mode_r == MODE_RUN);
    tick_s     = run_s && sec_tick;
    edit_s     = !run_s && !key_mode && (key_up ^ key_down);
    up_s       = edit_s && key_up;
    down_s     = edit_s && key_down;
    sec_inc_s  = tick_s || (up_s && (mode_r == MODE_SET_SEC));
    sec_dec_s  = down_s && (mode_r == MODE_SET_SEC);
    min_inc_s  = (tick_s && (sec_val_s == SEC_MAX)) || (up_s && (mode_r == MODE_SET_MIN));
    min_dec_s  = down_s && (mode_r == MODE_SET_MIN);
    hour_inc_s = (tick_s && (sec_val_s == SEC_MAX) && (min_val_s == MIN_MAX)) ||
                 (up_s && (mode_r == MODE_SET_HOUR));
    hour_dec_s = down_s && (mode_r == MODE_SET_HOUR);
  end

  // Mode sequencing and blink flag next state.
  always_comb begin
    mode_s  = mode_r;
    blink_s = blink_r;
    if (key_mode) begin
      case (mode_r)
        MODE_RUN:      mode_s = MODE_SET_HOUR;
        MODE_SET_HOUR: mode_s = MODE_SET_MIN;
        MODE_SET_MIN:  mode_s = MODE_SET_SEC;
        MODE_SET_SEC:  mode_s = MODE_RUN;
        default:       mode_s = MODE_RUN;
      endcase
      blink_s = 1'b1;
    end else if (run_s) begin
      mode_s  = mode_r;
      blink_s = 1'b1;
    end else if (edit_s) begin
      mode_s  = mode_r;
      blink_s = 1'b1;
    end else if (blink_tick) begin
      mode_s  = mode_r;
      blink_s = !blink_r;
    end else begin
      mode_s  = mode_r;
      blink_s = blink_r;
    end
  end

  // Mode and blink registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_r  <= MODE_RUN;
      blink_r <= 1'b1;
    end else begin
      mode_r  <= mode_s;
      blink_r <= blink_s;
    end
  end

  bcd_field_counter #(.MAX(HOUR_MAX), .INIT(INIT_HOUR)) u_hour (
    .clock (clock),
    .reset (reset),
    .inc   (hour_inc_s),
    .dec   (hour_dec_s),
    .value (hour_val_s),
    .carry (hour_carry_s)
  );

  bcd_field_counter #(.MAX(MIN_MAX), .INIT(INIT_MIN)) u_min (
    .clock (clock),
    .reset (reset),
    .inc   (min_inc_s),
    .dec   (min_dec_s),
    .value (min_val_s),
    .carry (min_carry_s)
  );

  bcd_field_counter #(.MAX(SEC_MAX), .INIT(INIT_SEC)) u_sec (
    .clock (clock),
    .reset (reset),
    .inc   (sec_inc_s),
    .dec   (sec_dec_s),
    .value (sec_val_s),
    .carry (sec_carry_s)
  );

  // All three fields wrap together only on the running 23:59:59 rollover.
  assign midnight = hour_carry_s && min_carry_s && sec_carry_s;
  assign hour_bcd = hour_val_s;
  assign min_bcd  = min_val_s;
  assign sec_bcd  = sec_val_s;
  assign mode     = mode_r;
  assign blink_on = blink_r;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: two instances (default init and
// 23:59:58 init) share stimulus; an integer-based model fills a scoreboard.
module tb_time_set_ctrl;

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    logic [1:0] md;
    logic       bl;
    logic       mid;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic sec_tick = 1'b0, blink_tick = 1'b0, key_mode = 1'b0, key_up = 1'b0, key_down = 1'b0;
  logic [7:0] hour0, min0, sec0, hour1, min1, sec1;
  logic [1:0] mode0, mode1;
  logic       blink0, blink1, mid0, mid1;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  int mh[2], mm[2], ms[2], mmd[2];
  bit mbl[2];

  always #5 clock = ~clock;

  time_set_ctrl dut0 (
    .clock(clock), .reset(reset), .sec_tick(sec_tick), .blink_tick(blink_tick),
    .key_mode(key_mode), .key_up(key_up), .key_down(key_down),
    .hour_bcd(hour0), .min_bcd(min0), .sec_bcd(sec0), .mode(mode0),
    .blink_on(blink0), .midnight(mid0)
  );

  time_set_ctrl #(.INIT_HOUR(8'h23), .INIT_MIN(8'h59), .INIT_SEC(8'h58)) dut1 (
    .clock(clock), .reset(reset), .sec_tick(sec_tick), .blink_tick(blink_tick),
    .key_mode(key_mode), .key_up(key_up), .key_down(key_down),
    .hour_bcd(hour1), .min_bcd(min1), .sec_bcd(sec1), .mode(mode1),
    .blink_on(blink1), .midnight(mid1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic exp_t snap(input int k, input bit mid);
    exp_t e;
    e.h = to_bcd(mh[k]);
    e.m = to_bcd(mm[k]);
    e.s = to_bcd(ms[k]);
    e.md = 2'(mmd[k]);
    e.bl = mbl[k];
    e.mid = mid;
    return e;
  endfunction

  function automatic exp_t obs(input int k);
    if (k == 0) return {hour0, min0, sec0, mode0, blink0, mid0};
    else        return {hour1, min1, sec1, mode1, blink1, mid1};
  endfunction

  task automatic model_reset();
    mh[0] = 0;  mm[0] = 0;  ms[0] = 0;
    mh[1] = 23; mm[1] = 59; ms[1] = 58;
    for (int k = 0; k < 2; k++) begin
      mmd[k] = 0;
      mbl[k] = 1'b1;
    end
  endtask

  // Reference model: one clock edge of behaviour in plain integer arithmetic.
  function automatic exp_t model_step(input int k, input bit t, input bit bt,
                                      input bit km, input bit ku, input bit kd);
    bit mid = 1'b0;
    if (mmd[k] == 0 && t) begin
      ms[k] = ms[k] + 1;
      if (ms[k] == 60) begin
        ms[k] = 0;
        mm[k] = mm[k] + 1;
        if (mm[k] == 60) begin
          mm[k] = 0;
          mh[k] = mh[k] + 1;
          if (mh[k] == 24) begin
            mh[k] = 0;
            mid = 1'b1;
          end
        end
      end
    end
    if (km) begin
      mmd[k] = (mmd[k] + 1) % 4;
      mbl[k] = 1'b1;
    end else if (mmd[k] != 0 && (ku != kd)) begin
      int d = ku ? 1 : -1;
      if (mmd[k] == 1) mh[k] = (mh[k] + d + 24) % 24;
      if (mmd[k] == 2) mm[k] = (mm[k] + d + 60) % 60;
      if (mmd[k] == 3) ms[k] = (ms[k] + d + 60) % 60;
      mbl[k] = 1'b1;
    end else if (mmd[k] != 0 && bt) begin
      mbl[k] = !mbl[k];
    end else if (mmd[k] == 0) begin
      mbl[k] = 1'b1;
    end
    return snap(k, mid);
  endfunction

  task automatic compare(input int k, input exp_t e);
    exp_t o = obs(k);
    check($sformatf("d%0d hour", k), 32'(o.h), 32'(e.h));
    check($sformatf("d%0d min", k), 32'(o.m), 32'(e.m));
    check($sformatf("d%0d sec", k), 32'(o.s), 32'(e.s));
    check($sformatf("d%0d mode", k), 32'(o.md), 32'(e.md));
    check($sformatf("d%0d blink", k), 32'(o.bl), 32'(e.bl));
    check($sformatf("d%0d midnight", k), 32'(o.mid), 32'(e.mid));
  endtask

  // One clock cycle: drive pulses at negedge, queue expectations, check after posedge.
  task automatic cyc(input bit t, input bit bt, input bit km, input bit ku, input bit kd);
    @(negedge clock);
    sec_tick = t; blink_tick = bt; key_mode = km; key_up = ku; key_down = kd;
    for (int k = 0; k < 2; k++) exp_q.push_back(model_step(k, t, bt, km, ku, kd));
    @(posedge clock);
    #1;
    sec_tick = 1'b0; blink_tick = 1'b0; key_mode = 1'b0; key_up = 1'b0; key_down = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (exp_q.size() == 0) begin
        check("scoreboard empty", 32'd1, 32'd0);
      end else begin
        compare(k, exp_q.pop_front());
      end
    end
  endtask

  task automatic check_init(input string tag);
    check({tag, " d0 hour"}, 32'(hour0), 32'h00);
    check({tag, " d0 min"}, 32'(min0), 32'h00);
    check({tag, " d0 sec"}, 32'(sec0), 32'h00);
    check({tag, " d0 mode"}, 32'(mode0), 32'd0);
    check({tag, " d0 blink"}, 32'(blink0), 32'd1);
    check({tag, " d0 midnight"}, 32'(mid0), 32'd0);
    check({tag, " d1 hour"}, 32'(hour1), 32'h23);
    check({tag, " d1 min"}, 32'(min1), 32'h59);
    check({tag, " d1 sec"}, 32'(sec1), 32'h58);
    check({tag, " d1 mode"}, 32'(mode1), 32'd0);
  endtask

  initial begin
    model_reset();
    #12;
    check_init("reset");
    @(negedge clock);
    reset = 1'b1;

    // Free run: 61 ticks; instance 1 crosses midnight on its second tick.
    for (int i = 0; i < 61; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 1) begin
        check("rollover hour", 32'(hour1), 32'h00);
        check("rollover min", 32'(min1), 32'h00);
        check("rollover sec", 32'(sec1), 32'h00);
        check("rollover midnight", 32'(mid1), 32'd1);
      end
      if (i == 2) check("midnight one cycle", 32'(mid1), 32'd0);
    end
    check("run61 hour", 32'(hour0), 32'h00);
    check("run61 min", 32'(min0), 32'h01);
    check("run61 sec", 32'(sec0), 32'h01);

    // SET_HOUR, decrement 00 -> 23, ticks ignored.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("set_hour mode", 32'(mode0), 32'd1);
    check("hour dec wrap", 32'(hour0), 32'h23);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("frozen sec", 32'(sec0), 32'h01);
    check("frozen min", 32'(min0), 32'h01);

    // SET_MIN: 01 -> 00 -> 59, up wraps to 00 without carry, then down to 10 and 09.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("min dec wrap", 32'(min0), 32'h59);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("min inc wrap", 32'(min0), 32'h00);
    check("min no carry", 32'(hour0), 32'h23);
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("min at 10", 32'(min0), 32'h10);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("min 10 to 09", 32'(min0), 32'h09);

    // SET_SEC: blink toggling, edit forces visible, exit to RUN.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("sec entry blink", 32'(blink0), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("blink toggle 1", 32'(blink0), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("blink toggle 2", 32'(blink0), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("edit forces blink", 32'(blink0), 32'd1);
    check("sec edited", 32'(sec0), 32'h02);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("back to run", 32'(mode0), 32'd0);
    check("run blink", 32'(blink0), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("resume count", 32'(sec0), 32'h03);

    // Simultaneous events.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("mode wins mode", 32'(mode0), 32'd2);
    check("mode wins hour", 32'(hour0), 32'h23);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("up+down min", 32'(min0), 32'h09);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("tick+mode sec", 32'(sec0), 32'h04);
    check("tick+mode mode", 32'(mode0), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0);
    end

    // Reach SET_MIN, then reset asynchronously between clock edges.
    for (int i = 0; i < 4; i++) begin
      if (mmd[0] != 2) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    check("pre-reset mode", 32'(mode0), 32'd2);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_init("async reset");
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post reset sec", 32'(sec0), 32'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
